// File: rtl/lex_stream_if.sv
// Source-byte and token channels between the lexer and its neighbours.
// Handshake: a transfer happens on a rising clk edge where valid & ready are both 1;
// the sender holds its payload stable while valid & !ready, and valid never waits on ready.
interface lex_stream_if #(
  parameter int NUM_W     = 32,
  parameter int IDENT_MAX = 8,
  parameter int POS_W     = 16
);
  localparam int LEN_W = $clog2(IDENT_MAX + 1);

  logic                   in_valid;
  logic                   in_ready;
  logic [7:0]             in_data;
  logic                   in_last;
  logic                   out_valid;
  logic                   out_ready;
  logic [1:0]             out_kind;
  logic [3:0]             out_op;
  logic [NUM_W-1:0]       out_num;
  logic [8*IDENT_MAX-1:0] out_ident;
  logic [LEN_W-1:0]       out_ident_len;
  logic [POS_W-1:0]       out_pos;
  logic                   err;
  logic [POS_W-1:0]       err_pos;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_kind, out_op, out_num, out_ident,
           out_ident_len, out_pos, err, err_pos
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_kind, out_op, out_num, out_ident,
           out_ident_len, out_pos, err, err_pos
  );
endinterface

// File: rtl/lex_stream.sv
// Streaming lexer: source bytes in, reserved-op / ident / num / eof tokens out,
// each tagged with the byte offset of its first character.
module lex_stream #(
  parameter int NUM_W     = 32,
  parameter int IDENT_MAX = 8,
  parameter int POS_W     = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  lex_stream_if.slave bus,
  output logic [2:0]  state_o
);
  localparam int LEN_W = $clog2(IDENT_MAX + 1);
  localparam int ID_W  = 8 * IDENT_MAX;

  typedef enum logic [2:0] {S_SCAN, S_NUM, S_IDENT, S_OP2, S_EOFE} state_e;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= "0") && (b <= "9");
  endfunction

  function automatic logic is_alpha(input logic [7:0] b);
    return ((b >= "a") && (b <= "z")) || ((b >= "A") && (b <= "Z")) || (b == "_");
  endfunction

  function automatic logic is_ws(input logic [7:0] b);
    return (b == " ") || (b == 8'h09) || (b == 8'h0d) || (b == 8'h0a);
  endfunction

  function automatic logic is_op2(input logic [7:0] b);
    return (b == "=") || (b == "!") || (b == "<") || (b == ">");
  endfunction

  // {hit, code} for the single-character reserved ops.
  function automatic logic [4:0] single_op(input logic [7:0] b);
    case (b)
      "+":     return {1'b1, 4'd0};
      "-":     return {1'b1, 4'd1};
      "*":     return {1'b1, 4'd2};
      "/":     return {1'b1, 4'd3};
      "(":     return {1'b1, 4'd4};
      ")":     return {1'b1, 4'd5};
      ";":     return {1'b1, 4'd6};
      default: return 5'd0;
    endcase
  endfunction

  function automatic logic [3:0] op2_code(input logic [7:0] c, input logic two);
    case (c)
      "=":     return two ? 4'd8 : 4'd7;
      "!":     return 4'd9;
      "<":     return two ? 4'd11 : 4'd10;
      default: return two ? 4'd13 : 4'd12;
    endcase
  endfunction

  state_e             state_q, state_d;
  logic [NUM_W-1:0]   acc_q, acc_d;
  logic [ID_W-1:0]    ident_q, ident_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [POS_W-1:0]   tok_pos_q, tok_pos_d;
  logic [7:0]         op2_q, op2_d;
  logic               last_q, last_d;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic               pend_valid_q, pend_valid_d;
  logic [7:0]         pend_data_q, pend_data_d;
  logic               pend_last_q, pend_last_d;
  logic [POS_W-1:0]   pend_pos_q, pend_pos_d;
  logic               err_q, err_d;
  logic [POS_W-1:0]   err_pos_q, err_pos_d;
  logic               alive_q;

  logic               out_valid_q;
  logic [1:0]         out_kind_q;
  logic [3:0]         out_op_q;
  logic [NUM_W-1:0]   out_num_q;
  logic [ID_W-1:0]    out_ident_q;
  logic [LEN_W-1:0]   out_len_q;
  logic [POS_W-1:0]   out_pos_q;

  logic               can_emit, in_ready, in_fire, use_pend, cur_valid, cur_last, to_pend;
  logic [7:0]         cur_b;
  logic [POS_W-1:0]   cur_pos;
  logic [4:0]         sop;
  logic               emit;
  logic [1:0]         e_kind;
  logic [3:0]         e_op;
  logic [NUM_W-1:0]   e_num;
  logic [ID_W-1:0]    e_ident;
  logic [LEN_W-1:0]   e_len;
  logic [POS_W-1:0]   e_pos;

  // last_q also holds input off while the tail token and eof drain out, so the
  // next source text cannot mix into the one being closed.
  assign can_emit  = !out_valid_q || bus.out_ready;
  assign in_ready  = alive_q && !pend_valid_q && !err_q && !last_q && can_emit;
  assign in_fire   = bus.in_valid && in_ready;
  assign use_pend  = pend_valid_q && can_emit && !err_q;
  assign cur_valid = use_pend || in_fire;
  assign cur_b     = use_pend ? pend_data_q : bus.in_data;
  assign cur_last  = use_pend ? pend_last_q : bus.in_last;
  assign cur_pos   = use_pend ? pend_pos_q  : pos_q;
  assign sop       = single_op(cur_b);

  always_comb begin
    state_d = state_q;  acc_d = acc_q;  ident_d = ident_q;  len_d = len_q;
    tok_pos_d = tok_pos_q;  op2_d = op2_q;  last_d = last_q;  pos_d = pos_q;
    pend_valid_d = pend_valid_q;  pend_data_d = pend_data_q;
    pend_last_d = pend_last_q;  pend_pos_d = pend_pos_q;
    err_d = err_q;  err_pos_d = err_pos_q;
    to_pend = 1'b0;  emit = 1'b0;  e_kind = 2'd0;  e_op = 4'd0;  e_num = '0;
    e_ident = '0;  e_len = '0;  e_pos = '0;

    if (in_fire)  pos_d = pos_q + POS_W'(1);
    if (use_pend) pend_valid_d = 1'b0;

    if (cur_valid) begin
      case (state_q)
        S_SCAN: begin
          if (is_ws(cur_b)) begin
            if (cur_last) begin state_d = S_EOFE; last_d = 1'b1; end
          end else if (is_digit(cur_b)) begin
            state_d = S_NUM;  acc_d = NUM_W'(cur_b[3:0]);
            tok_pos_d = cur_pos;  last_d = cur_last;
          end else if (is_alpha(cur_b)) begin
            state_d = S_IDENT;  ident_d = '0;  ident_d[7:0] = cur_b;
            len_d = LEN_W'(1);  tok_pos_d = cur_pos;  last_d = cur_last;
          end else if (sop[4]) begin
            emit = 1'b1;  e_op = sop[3:0];  e_pos = cur_pos;
            if (cur_last) begin state_d = S_EOFE; last_d = 1'b1; end
          end else if (is_op2(cur_b)) begin
            state_d = S_OP2;  op2_d = cur_b;  tok_pos_d = cur_pos;  last_d = cur_last;
          end else begin
            err_d = 1'b1;  err_pos_d = cur_pos;
          end
        end
        S_NUM: begin
          if (is_digit(cur_b)) begin
            acc_d = acc_q * NUM_W'(10) + NUM_W'(cur_b[3:0]);
            last_d = cur_last;
          end else begin
            emit = 1'b1;  e_kind = 2'd2;  e_num = acc_q;  e_pos = tok_pos_q;
            to_pend = 1'b1;  state_d = S_SCAN;
          end
        end
        S_IDENT: begin
          if (is_alpha(cur_b) || is_digit(cur_b)) begin
            if (len_q == LEN_W'(IDENT_MAX)) begin
              err_d = 1'b1;  err_pos_d = cur_pos;
            end else begin
              for (int i = 0; i < IDENT_MAX; i++)
                if (LEN_W'(i) == len_q) ident_d[8*i +: 8] = cur_b;
              len_d = len_q + LEN_W'(1);  last_d = cur_last;
            end
          end else begin
            emit = 1'b1;  e_kind = 2'd1;  e_ident = ident_q;  e_len = len_q;
            e_pos = tok_pos_q;  to_pend = 1'b1;  state_d = S_SCAN;
          end
        end
        S_OP2: begin
          if (cur_b == "=") begin
            emit = 1'b1;  e_op = op2_code(op2_q, 1'b1);  e_pos = tok_pos_q;
            state_d = cur_last ? S_EOFE : S_SCAN;  last_d = cur_last;
          end else if (op2_q == "!") begin
            err_d = 1'b1;  err_pos_d = tok_pos_q;
          end else begin
            emit = 1'b1;  e_op = op2_code(op2_q, 1'b0);  e_pos = tok_pos_q;
            to_pend = 1'b1;  state_d = S_SCAN;
          end
        end
        default: ;
      endcase
    end else if (last_q && can_emit && !err_q) begin
      // End of text: close the open token, then emit eof and start a new text.
      state_d = S_EOFE;
      case (state_q)
        S_NUM: begin
          emit = 1'b1;  e_kind = 2'd2;  e_num = acc_q;  e_pos = tok_pos_q;
        end
        S_IDENT: begin
          emit = 1'b1;  e_kind = 2'd1;  e_ident = ident_q;  e_len = len_q;  e_pos = tok_pos_q;
        end
        S_OP2: begin
          if (op2_q == "!") begin
            err_d = 1'b1;  err_pos_d = tok_pos_q;
          end else begin
            emit = 1'b1;  e_op = op2_code(op2_q, 1'b0);  e_pos = tok_pos_q;
          end
        end
        default: begin
          emit = 1'b1;  e_kind = 2'd3;  e_pos = pos_q;
          pos_d = '0;  last_d = 1'b0;  state_d = S_SCAN;
        end
      endcase
    end

    if (to_pend) begin
      pend_valid_d = 1'b1;  pend_data_d = cur_b;  pend_last_d = cur_last;  pend_pos_d = cur_pos;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_SCAN;  acc_q <= '0;  ident_q <= '0;  len_q <= '0;
      tok_pos_q <= '0;  op2_q <= '0;  last_q <= 1'b0;  pos_q <= '0;
      pend_valid_q <= 1'b0;  pend_data_q <= '0;  pend_last_q <= 1'b0;  pend_pos_q <= '0;
      err_q <= 1'b0;  err_pos_q <= '0;  alive_q <= 1'b0;
      out_valid_q <= 1'b0;  out_kind_q <= '0;  out_op_q <= '0;  out_num_q <= '0;
      out_ident_q <= '0;  out_len_q <= '0;  out_pos_q <= '0;
    end else begin
      state_q <= state_d;  acc_q <= acc_d;  ident_q <= ident_d;  len_q <= len_d;
      tok_pos_q <= tok_pos_d;  op2_q <= op2_d;  last_q <= last_d;  pos_q <= pos_d;
      pend_valid_q <= pend_valid_d;  pend_data_q <= pend_data_d;
      pend_last_q <= pend_last_d;  pend_pos_q <= pend_pos_d;
      err_q <= err_d;  err_pos_q <= err_pos_d;  alive_q <= 1'b1;
      if (err_d) begin
        out_valid_q <= 1'b0;
      end else if (emit) begin
        out_valid_q <= 1'b1;  out_kind_q <= e_kind;  out_op_q <= e_op;  out_num_q <= e_num;
        out_ident_q <= e_ident;  out_len_q <= e_len;  out_pos_q <= e_pos;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready      = in_ready;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_kind      = out_kind_q;
  assign bus.out_op        = out_op_q;
  assign bus.out_num       = out_num_q;
  assign bus.out_ident     = out_ident_q;
  assign bus.out_ident_len = out_len_q;
  assign bus.out_pos       = out_pos_q;
  assign bus.err           = err_q;
  assign bus.err_pos       = err_pos_q;
  assign state_o           = state_q;
endmodule

// File: tb/tb_lex_stream.sv
// Bench for lex_stream: directed texts plus random source texts, scored against a
// string-scanning reference tokenizer through an expected-token queue.
module tb_lex_stream;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] state_dbg;

  lex_stream_if bus ();
  lex_stream dut (.clk(clk), .rst_n(rst_n), .bus(bus), .state_o(state_dbg));

  always #5 clk = ~clk;

  logic [121:0] exp_q[$];
  logic [121:0] model_q[$];
  logic [7:0]   txt[$];
  int checks = 0;
  int errors = 0;
  int ready_mode = 0;
  int gap_max = 0;

  function automatic void chk(string name, logic [127:0] act, logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endfunction

  function automatic logic [121:0] mk(logic [1:0] k, logic [3:0] op, logic [31:0] num,
                                      logic [63:0] id, logic [3:0] len, int pos);
    return {k, op, num, id, len, 16'(pos)};
  endfunction

  function automatic bit m_digit(logic [7:0] c); return c >= "0" && c <= "9"; endfunction
  function automatic bit m_word(logic [7:0] c);
    return (c >= "a" && c <= "z") || (c >= "A" && c <= "Z") || c == "_" || m_digit(c);
  endfunction

  // Reference tokenizer over a whole text; returns error offset or -1.
  function automatic int model(input logic [7:0] t[$]);
    int i = 0;
    int n = t.size();
    model_q.delete();
    while (i < n) begin
      logic [7:0] c = t[i];
      if (c == " " || c == 8'h09 || c == 8'h0a || c == 8'h0d) begin
        i++;
      end else if (m_digit(c)) begin
        int start = i;
        logic [31:0] v = 0;
        while (i < n && m_digit(t[i])) begin v = v * 10 + 32'(t[i] - 8'h30); i++; end
        model_q.push_back(mk(2'd2, 4'd0, v, 64'd0, 4'd0, start));
      end else if (m_word(c)) begin
        int start = i;
        int len = 0;
        logic [63:0] id = 0;
        while (i < n && m_word(t[i])) begin
          if (len == 8) return start + 8;
          id[8*len +: 8] = t[i];
          len++; i++;
        end
        model_q.push_back(mk(2'd1, 4'd0, 32'd0, id, 4'(len), start));
      end else begin
        int code = -1;
        bit two = (i + 1 < n) && (t[i+1] == "=");
        case (c)
          "+": code = 0;  "-": code = 1;  "*": code = 2;  "/": code = 3;
          "(": code = 4;  ")": code = 5;  ";": code = 6;
          "=": code = two ? 8 : 7;
          "!": code = two ? 9 : -1;
          "<": code = two ? 11 : 10;
          ">": code = two ? 13 : 12;
          default: code = -1;
        endcase
        if (code < 0) return i;
        model_q.push_back(mk(2'd0, 4'(code), 32'd0, 64'd0, 4'd0, i));
        i += (two && c inside {"=", "!", "<", ">"}) ? 2 : 1;
      end
    end
    model_q.push_back(mk(2'd3, 4'd0, 32'd0, 64'd0, 4'd0, n));
    return -1;
  endfunction

  function automatic void load(string s);
    txt.delete();
    for (int i = 0; i < s.len(); i++) txt.push_back(s[i]);
  endfunction

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       bus.out_ready = 1'b1;
      1:       bus.out_ready = ($urandom_range(0, 3) != 0);
      default: bus.out_ready = 1'b0;
    endcase
  end

  task automatic send(input bit with_last);
    int b;
    bit ok;
    @(posedge clk); #1;
    for (int i = 0; i < txt.size(); i++) begin
      bus.in_valid = 1'b0;
      repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
      bus.in_valid = 1'b1;
      bus.in_data  = txt[i];
      bus.in_last  = with_last && (i == txt.size() - 1);
      b = 0; ok = 1'b0;
      while (!ok && b < 500) begin @(negedge clk); ok = bus.in_ready; b++; end
      @(posedge clk); #1;
      if (!ok) begin
        checks++; errors++;
        $display("FAIL in_accept: byte %0d waited %0d cycles, required acceptance", i, b);
        break;
      end
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic run_txt(output int e);
    e = model(txt);
    foreach (model_q[i]) exp_q.push_back(model_q[i]);
    send(1'b1);
  endtask

  task automatic run_str(string s);
    int e;
    load(s);
    run_txt(e);
  endtask

  task automatic wait_drain();
    int b = 0;
    while (exp_q.size() != 0 && b < 3000) begin @(negedge clk); b++; end
    repeat (5) @(negedge clk);
    chk("drain_left", 128'(exp_q.size()), 128'(0));
    exp_q.delete();
  endtask

  task automatic check_reset_values(string tag);
    chk({tag, "_in_ready"}, 128'(bus.in_ready), 128'(0));
    chk({tag, "_out_valid"}, 128'(bus.out_valid), 128'(0));
    chk({tag, "_err"}, 128'({bus.err, bus.err_pos}), 128'(0));
    chk({tag, "_out"}, 128'({bus.out_kind, bus.out_op, bus.out_num, bus.out_ident,
                             bus.out_ident_len, bus.out_pos}), 128'(0));
    chk({tag, "_state"}, 128'(state_dbg), 128'(0));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_values("rst_mid");
    exp_q.delete();
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  logic [121:0] prev_tok;
  bit prev_stall = 1'b0;
  always @(negedge clk) begin
    logic [121:0] cur;
    logic [121:0] want;
    cur = {bus.out_kind, bus.out_op, bus.out_num, bus.out_ident, bus.out_ident_len, bus.out_pos};
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) chk("stall_stable", 128'({bus.out_valid, cur}), 128'({1'b1, prev_tok}));
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL token_extra: got %0h required no token", cur);
        end else begin
          want = exp_q.pop_front();
          chk("token", 128'(cur), 128'(want));
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_tok = cur;
    end
  end

  initial begin
    string pal;
    int e;
    int tries;
    pal = "abzQ_01799    +-*/();=<>!\t\n";
    bus.in_valid = 1'b0; bus.in_data = 8'd0; bus.in_last = 1'b0; bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("rst");
    rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("ready_after_rst", 128'(bus.in_ready), 128'(1));

    ready_mode = 0;
    run_str("a1=42;");
    run_str(">= > = <=1");
    run_str("4294967297;");
    run_str(" \t\n");
    run_str("abcdefgh!=x_9(7)*2/3-1");
    wait_drain();

    ready_mode = 2;
    fork
      run_str("1+2;");
      begin repeat (20) @(posedge clk); ready_mode = 0; end
    join
    wait_drain();

    ready_mode = 1;
    gap_max = 2;
    for (int k = 0; k < 40; k++) begin
      tries = 0;
      do begin
        txt.delete();
        for (int j = 0; j < $urandom_range(1, 14); j++)
          txt.push_back(pal[$urandom_range(0, pal.len() - 1)]);
        tries++;
      end while (model(txt) != -1 && tries < 50);
      if (model(txt) != -1) load("ok;");
      run_txt(e);
    end
    wait_drain();

    ready_mode = 0;
    gap_max = 0;
    load("x@");
    run_txt(e);
    repeat (4) @(negedge clk);
    chk("err_x_at", 128'({bus.err, bus.err_pos}), 128'({1'b1, 16'(e)}));
    chk("err_x_hold", 128'({bus.in_ready, bus.out_valid}), 128'(0));
    chk("err_x_tokens", 128'(exp_q.size()), 128'(0));
    do_reset();

    load("abcdefghi");
    run_txt(e);
    repeat (4) @(negedge clk);
    chk("err_long", 128'({bus.err, bus.err_pos}), 128'({1'b1, 16'd8}));
    chk("err_long_pos_model", 128'(e), 128'(8));
    do_reset();

    load("12");
    send(1'b0);
    do_reset();
    run_str("7;");
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
